// File: rtl/fifo_read_control_pkg.sv
// Shared definitions for the feature-map FIFO read controller: state encoding,
// index width and default frame geometry.
package fifo_read_control_pkg;

  localparam int IDX_W       = 10;
  localparam int DEF_FRAME_W = 64;
  localparam int DEF_FRAME_H = 64;
  localparam int DEF_DATA_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_read_skid.sv
// Output register plus one-entry skid buffer carrying pixel data and its x/y tag.
module fifo_read_skid #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [IDX_W-1:0]  i_x,
  input  logic [IDX_W-1:0]  i_y,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [IDX_W-1:0]  o_x,
  output logic [IDX_W-1:0]  o_y,
  input  logic              i_ready
);

  localparam int ENT_W = DATA_W + 2 * IDX_W;

  logic             r_out_valid;
  logic             r_skid_valid;
  logic [ENT_W-1:0] r_out;
  logic [ENT_W-1:0] r_skid;
  logic [ENT_W-1:0] w_in;
  logic             w_consume;

  // Handshake: downstream takes a beat when o_valid & i_ready. Upstream may only
  // launch a beat while o_ready is high; that beat arrives here the next cycle.
  assign w_in      = {i_data, i_x, i_y};
  assign w_consume = r_out_valid & i_ready;
  assign o_ready   = ~r_skid_valid;
  assign o_valid   = r_out_valid;
  assign {o_data, o_x, o_y} = r_out;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (w_consume) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_skid_valid <= 1'b0;
      end else if (i_valid) begin
        r_out <= w_in;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (!r_out_valid) begin
      if (i_valid) begin
        r_out       <= w_in;
        r_out_valid <= 1'b1;
      end
    end else if (i_valid) begin
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fifo_read_control.sv
// Drains one frame from the feature-map FIFO in raster order as an x/y tagged
// valid/ready stream. Define FIFO_READ_PAD_EN to wrap the frame in a zero border.
module fifo_read_control
  import fifo_read_control_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_fifoEmpty,
  input  logic [DATA_W-1:0] i_fifoData,
  input  logic              i_ready,
  output logic              o_eReadFifo,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [IDX_W-1:0]  o_xIndex,
  output logic [IDX_W-1:0]  o_yIndex,
  output logic              o_process,
  output logic              o_complete,
  output logic [1:0]        o_state
);

`ifdef FIFO_READ_PAD_EN
  localparam int OW = FRAME_W + 2;
  localparam int OH = FRAME_H + 2;
`else
  localparam int OW = FRAME_W;
  localparam int OH = FRAME_H;
`endif
  localparam logic [IDX_W-1:0] X_LAST = IDX_W'(OW - 1);
  localparam logic [IDX_W-1:0] Y_LAST = IDX_W'(OH - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_x;
  logic [IDX_W-1:0]   r_y;
  logic               r_inflight;
  logic               r_inflight_pad;
  logic [IDX_W-1:0]   r_inflight_x;
  logic [IDX_W-1:0]   r_inflight_y;
  logic               r_process;
  logic               r_complete;
  logic               w_pad;
  logic               w_issue;
  logic               w_skid_ready;
  logic [DATA_W-1:0]  w_ret_data;

`ifdef FIFO_READ_PAD_EN
  assign w_pad = (r_x == '0) || (r_x == X_LAST) || (r_y == '0) || (r_y == Y_LAST);
`else
  assign w_pad = 1'b0;
`endif

  // Only issue when the skid is empty, so the single in-flight beat always has a home.
  assign w_issue     = (r_state == ST_READ) & i_ready & w_skid_ready & (~i_fifoEmpty | w_pad);
  assign o_eReadFifo = w_issue & ~w_pad;
  assign w_ret_data  = r_inflight_pad ? '0 : i_fifoData;
  assign o_process   = r_process;
  assign o_complete  = r_complete;
  assign o_state     = r_state;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= ST_IDLE;
      r_x            <= '0;
      r_y            <= '0;
      r_inflight     <= 1'b0;
      r_inflight_pad <= 1'b0;
      r_inflight_x   <= '0;
      r_inflight_y   <= '0;
      r_process      <= 1'b0;
      r_complete     <= 1'b1;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pad <= w_pad;
        r_inflight_x   <= r_x;
        r_inflight_y   <= r_y;
      end
      case (r_state)
        ST_IDLE: begin
          r_x <= '0;
          r_y <= '0;
          if (i_start) begin
            r_state    <= ST_READ;
            r_process  <= 1'b1;
            r_complete <= 1'b0;
          end
        end
        ST_READ: begin
          if (w_issue) begin
            if (r_x == X_LAST) begin
              r_x <= '0;
              if (r_y == Y_LAST) r_state <= ST_DRAIN;
              else               r_y     <= r_y + 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!r_inflight && !o_valid && w_skid_ready) begin
            r_state    <= ST_FINISH;
            r_process  <= 1'b0;
            r_complete <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  fifo_read_skid #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_skid (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (r_inflight),
    .i_data  (w_ret_data),
    .i_x     (r_inflight_x),
    .i_y     (r_inflight_y),
    .o_ready (w_skid_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_x     (o_xIndex),
    .o_y     (o_yIndex),
    .i_ready (i_ready)
  );

endmodule

// File: tb/tb_fifo_read_control.sv
// Bench for fifo_read_control: FIFO model, raster-order reference frame and
// directed/random frames. Honours FIFO_READ_PAD_EN like the design.
module tb_fifo_read_control;
  import fifo_read_control_pkg::*;

  localparam int FW = 64;
  localparam int FH = 64;
  localparam int DW = 8;
`ifdef FIFO_READ_PAD_EN
  localparam bit PAD = 1'b1;
  localparam int OW  = FW + 2;
  localparam int OH  = FH + 2;
`else
  localparam bit PAD = 1'b0;
  localparam int OW  = FW;
  localparam int OH  = FH;
`endif
  localparam int EW     = DW + 20;
  localparam int SPAN   = PAD ? (OH - 2) * OW - 2 : FW * FH;
  localparam int BUDGET = 30000;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic          i_fifoEmpty;
  logic [DW-1:0] i_fifoData;
  logic          i_ready;
  logic          o_eReadFifo;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic [9:0]    o_xIndex;
  logic [9:0]    o_yIndex;
  logic          o_process;
  logic          o_complete;
  logic [1:0]    o_state;

  fifo_read_control #(.FRAME_W(FW), .FRAME_H(FH), .DATA_W(DW)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_fifoEmpty (i_fifoEmpty),
    .i_fifoData  (i_fifoData),
    .i_ready     (i_ready),
    .o_eReadFifo (o_eReadFifo),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_xIndex    (o_xIndex),
    .o_yIndex    (o_yIndex),
    .o_process   (o_process),
    .o_complete  (o_complete),
    .o_state     (o_state)
  );

  always #5 i_clk = ~i_clk;

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;
  logic [DW-1:0] fifo_q[$];
  logic [EW-1:0] exp_q[$];
  bit            force_empty;
  bit            prev_stall;
  logic [EW-1:0] prev_out;
  int            beats, reads, first_read, last_read, first_beat, last_beat;
  logic [9:0]    last_bx, last_by;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge+1, FIFO model answers a read one cycle later.
  task automatic tick();
    logic          rd;
    logic          bt;
    logic [EW-1:0] obs;
    i_fifoEmpty = force_empty || (fifo_q.size() == 0);
    #1;
    rd  = o_eReadFifo;
    bt  = o_valid && i_ready;
    obs = {o_yIndex, o_xIndex, o_data};
    check("read_while_empty", {31'b0, rd & i_fifoEmpty}, 32'd0);
    if (prev_stall) check("stall_hold", {3'b0, o_valid, obs}, {3'b0, 1'b1, prev_out});
    if (bt) begin
      check("beat_expected", {31'b0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) check("beat", {4'b0, obs}, {4'b0, exp_q.pop_front()});
      beats++;
      last_beat = cyc;
      if (first_beat < 0) first_beat = cyc;
      last_bx = o_xIndex;
      last_by = o_yIndex;
    end
    prev_stall = o_valid && !i_ready;
    prev_out   = obs;
    if (rd) begin
      reads++;
      last_read = cyc;
      if (first_read < 0) first_read = cyc;
    end
    @(posedge i_clk);
    #1;
    if (rd && fifo_q.size() > 0) i_fifoData = fifo_q.pop_front();
    cyc++;
    @(negedge i_clk);
  endtask

  // Reference frame: FIFO words in order, border beats (padded build) are zero.
  task automatic load_frame();
    logic [DW-1:0] words[$];
    logic [DW-1:0] w;
    logic [DW-1:0] d;
    for (int i = 0; i < FW * FH; i++) begin
      w = DW'($urandom);
      fifo_q.push_back(w);
      words.push_back(w);
    end
    for (int y = 0; y < OH; y++) begin
      for (int x = 0; x < OW; x++) begin
        if (PAD && (x == 0 || x == OW - 1 || y == 0 || y == OH - 1)) d = '0;
        else d = words.pop_front();
        exp_q.push_back({10'(y), 10'(x), d});
      end
    end
  endtask

  task automatic run_frame(input bit hold_start, input bit rnd, input bit directed,
                           input bit full_rate, input int abort_at);
    int c = 0;
    int stall_n = 0;
    int empty_n = 0;
    int start_cyc = -1;
    int proc_cyc = -1;
    bit started = 0;
    bit bp_done = 0;
    bit uf_done = 0;
    int target;
    target = (abort_at > 0) ? abort_at : OW * OH;
    load_frame();
    beats = 0; reads = 0; first_read = -1; first_beat = -1;
    while (beats < target && c < BUDGET) begin
      if (o_process && !started) begin
        started  = 1;
        proc_cyc = cyc;
      end
      i_start = hold_start | ~started;
      if (!started && start_cyc < 0) start_cyc = cyc;
      if (stall_n > 0) begin
        i_ready = 1'b0;
        stall_n--;
      end else if (directed && !bp_done && o_valid && o_xIndex == 10'd20 && o_yIndex == 10'd5) begin
        i_ready = 1'b0;
        stall_n = 2;
        bp_done = 1;
      end else begin
        i_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (empty_n > 0) begin
        force_empty = 1'b1;
        empty_n--;
      end else if (directed && !uf_done && o_valid && o_xIndex == 10'd40 && o_yIndex == 10'd10) begin
        force_empty = 1'b1;
        empty_n = 4;
        uf_done = 1;
      end else begin
        force_empty = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      end
      tick();
      c++;
    end
    check("frame_beats", beats, target);
    if (abort_at > 0) return;
    if (full_rate) begin
      check("start_latency", proc_cyc, start_cyc + 1);
      check("first_read", first_read, proc_cyc + (PAD ? OW + 1 : 0));
      check("read_span", last_read - first_read + 1, SPAN);
      check("beat_span", last_beat - first_beat + 1, OW * OH);
    end
    i_ready = 1'b1;
    force_empty = 1'b0;
    i_start = hold_start;
    tick();
    #1;
    check("complete_after_last", {30'b0, o_complete, o_process}, 32'd2);
    check("last_beat_xy", {12'b0, last_by, last_bx}, {12'b0, 10'(OH - 1), 10'(OW - 1)});
    check("fifo_reads", reads, FW * FH);
    check("exp_left", exp_q.size(), 0);
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_eread"},   {31'b0, o_eReadFifo}, 32'd0);
    check({tag, "_valid"},   {31'b0, o_valid}, 32'd0);
    check({tag, "_data"},    {24'b0, o_data}, 32'd0);
    check({tag, "_x"},       {22'b0, o_xIndex}, 32'd0);
    check({tag, "_y"},       {22'b0, o_yIndex}, 32'd0);
    check({tag, "_process"}, {31'b0, o_process}, 32'd0);
    check({tag, "_complete"}, {31'b0, o_complete}, 32'd1);
    check({tag, "_state"},   {30'b0, o_state}, {30'b0, ST_IDLE});
  endtask

  initial begin
    i_reset = 1'b0; i_start = 1'b0; i_ready = 1'b1; i_fifoData = '0;
    i_fifoEmpty = 1'b1; force_empty = 1'b0; prev_stall = 1'b0; prev_out = '0;
    @(negedge i_clk);
    #1;
    check_reset_values("reset");
    @(negedge i_clk);
    i_reset = 1'b1;
    cyc = 0;
    for (int i = 0; i < 10; i++) tick();
    #1;
    check("idle_complete", {31'b0, o_complete}, 32'd1);
    // Full-rate frame: start pulse at cycle 10.
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 0);
    // Backpressure at (20,5), FIFO empty mid-row, start held through the frame.
    run_frame(1'b1, 1'b0, 1'b1, 1'b0, 0);
    // Random stalls and empties.
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 0);
    // Async reset mid-frame.
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1000);
    #3;
    i_reset = 1'b0;
    #1;
    check_reset_values("midreset");
    fifo_q.delete();
    exp_q.delete();
    prev_stall = 1'b0;
    i_start = 1'b0;
    force_empty = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    tick();
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
